// File: rtl/axi_stream_monitor_sink_pkg.sv
// Shared constants and helpers for the AXI-Stream monitor sink.
package axi_stream_monitor_sink_pkg;

    localparam int unsigned READY_MODE_ALWAYS   = 0;
    localparam int unsigned READY_MODE_LFSR     = 1;
    localparam int unsigned READY_MODE_PERIODIC = 2;

    localparam int unsigned ERR_VALID_DROP     = 0;
    localparam int unsigned ERR_PAYLOAD_CHANGE = 1;
    localparam int unsigned ERR_W              = 2;
    localparam int unsigned CNT_W              = 32;

    // Captured record layout: {tlast, tuser, tid, tdest, tkeep, tstrb, tdata}
    function automatic int unsigned rec_width(input int unsigned data_w, input int unsigned id_w,
                                              input int unsigned dest_w, input int unsigned user_w);
        return 1 + user_w + id_w + dest_w + 2 * (data_w / 8) + data_w;
    endfunction

    // Fibonacci LFSR, taps x^16+x^14+x^13+x^11+1
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

endpackage

// File: rtl/axi_stream_monitor_sink_if.sv
// AXI-Stream handshake/payload bundle observed by the monitor sink.
interface axi_stream_monitor_sink_if #(
    parameter int unsigned TDATA_WIDTH = 16,
    parameter int unsigned TID_WIDTH   = 1,
    parameter int unsigned TDEST_WIDTH = 1,
    parameter int unsigned TUSER_WIDTH = 1
) ();
    logic [TDATA_WIDTH-1:0]   tdata;
    logic [TDATA_WIDTH/8-1:0] tstrb;
    logic [TDATA_WIDTH/8-1:0] tkeep;
    logic                     tlast;
    logic [TID_WIDTH-1:0]     tid;
    logic [TDEST_WIDTH-1:0]   tdest;
    logic [TUSER_WIDTH-1:0]   tuser;
    logic                     tvalid;
    logic                     tready;

    modport master (output tdata, tstrb, tkeep, tlast, tid, tdest, tuser, tvalid, input tready);
    modport slave  (input tdata, tstrb, tkeep, tlast, tid, tdest, tuser, tvalid, output tready);
endinterface

// File: rtl/axi_stream_monitor_sink_ready_gen.sv
// Backpressure pattern generator: always / seeded LFSR / periodic duty, registered tready.
module axi_stream_monitor_sink_ready_gen
    import axi_stream_monitor_sink_pkg::*;
#(
    parameter int unsigned READY_MODE   = READY_MODE_ALWAYS,
    parameter int unsigned READY_THRESH = 128,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter int unsigned READY_PERIOD = 4,
    parameter int unsigned READY_DUTY   = 2
) (
    input  logic aclk,
    input  logic aresetn,
    output logic tready
);
    localparam int unsigned     PH_W    = (READY_PERIOD > 1) ? $clog2(READY_PERIOD) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(READY_PERIOD - 1);

    logic [15:0]     lfsr_q, lfsr_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic            ready_d;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            lfsr_q  <= LFSR_SEED;
            phase_q <= '0;
            tready  <= 1'b0;
        end else begin
            lfsr_q  <= lfsr_d;
            phase_q <= phase_d;
            tready  <= ready_d;
        end
    end

    // Pattern depends only on generator state, never on tvalid.
    always_comb begin
        lfsr_d  = lfsr_step(lfsr_q);
        phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
        ready_d = 1'b1;
        case (READY_MODE)
            READY_MODE_LFSR:     ready_d = ({1'b0, lfsr_q[7:0]} < 9'(READY_THRESH));
            READY_MODE_PERIODIC: ready_d = (32'(phase_q) < 32'(READY_DUTY));
            default:             ready_d = 1'b1;
        endcase
    end

endmodule

// File: rtl/axi_stream_monitor_sink.sv
// AXI-Stream monitor sink: backpressure, beat capture, beat/packet counters, stability checks.
// Optional per-handshake logging is compiled in with AXIS_SINK_DISPLAY_EN.
module axi_stream_monitor_sink
    import axi_stream_monitor_sink_pkg::*;
#(
    parameter int unsigned TDATA_WIDTH   = 16,
    parameter int unsigned TID_WIDTH     = 1,
    parameter int unsigned TDEST_WIDTH   = 1,
    parameter int unsigned TUSER_WIDTH   = 1,
    parameter int unsigned CAPTURE_DEPTH = 64,
    parameter int unsigned READY_MODE    = READY_MODE_ALWAYS,
    parameter int unsigned READY_THRESH  = 128,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    parameter int unsigned READY_PERIOD  = 4,
    parameter int unsigned READY_DUTY    = 2,
    localparam int unsigned KEEP_W = TDATA_WIDTH / 8,
    localparam int unsigned AW     = $clog2(CAPTURE_DEPTH),
    localparam int unsigned REC_W  = rec_width(TDATA_WIDTH, TID_WIDTH, TDEST_WIDTH, TUSER_WIDTH)
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    axi_stream_monitor_sink_if.slave  s_axis,
    input  logic                      clear_in,
    input  logic [AW-1:0]             rd_addr_in,
    output logic [REC_W-1:0]          rd_data_out,
    output logic [AW:0]               capture_cnt_out,
    output logic                      capture_full_out,
    output logic [CNT_W-1:0]          beat_cnt_out,
    output logic [CNT_W-1:0]          pkt_cnt_out,
    output logic [ERR_W-1:0]          err_flags_out
);
    typedef struct packed {
        logic                   tlast;
        logic [TUSER_WIDTH-1:0] tuser;
        logic [TID_WIDTH-1:0]   tid;
        logic [TDEST_WIDTH-1:0] tdest;
        logic [KEEP_W-1:0]      tkeep;
        logic [KEEP_W-1:0]      tstrb;
        logic [TDATA_WIDTH-1:0] tdata;
    } rec_t;

    localparam logic [AW:0] LAST_IDX = (AW + 1)'(CAPTURE_DEPTH - 1);

    logic             tready_q;
    logic             hs, drop_set, chg_set;
    rec_t             in_rec, snap_q;
    rec_t             mem [CAPTURE_DEPTH];
    logic             stalled_q;
    logic [AW:0]      cnt_q;
    logic             full_q;
    logic [CNT_W-1:0] beat_q, pkt_q;
    logic [ERR_W-1:0] err_q;
    logic [REC_W-1:0] rd_q;

    axi_stream_monitor_sink_ready_gen #(
        .READY_MODE   (READY_MODE),
        .READY_THRESH (READY_THRESH),
        .LFSR_SEED    (LFSR_SEED),
        .READY_PERIOD (READY_PERIOD),
        .READY_DUTY   (READY_DUTY)
    ) u_ready_gen (
        .aclk    (aclk),
        .aresetn (aresetn),
        .tready  (tready_q)
    );

    assign s_axis.tready = tready_q;

    always_comb begin
        in_rec.tlast = s_axis.tlast;
        in_rec.tuser = s_axis.tuser;
        in_rec.tid   = s_axis.tid;
        in_rec.tdest = s_axis.tdest;
        in_rec.tkeep = s_axis.tkeep;
        in_rec.tstrb = s_axis.tstrb;
        in_rec.tdata = s_axis.tdata;
    end

    assign hs       = s_axis.tvalid & tready_q;
    assign drop_set = stalled_q & ~s_axis.tvalid;
    assign chg_set  = stalled_q & s_axis.tvalid & (in_rec != snap_q);

    // Counters, capture pointer and sticky stability flags; clear overrides a same-cycle beat.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            stalled_q <= 1'b0;
            snap_q    <= '0;
            cnt_q     <= '0;
            full_q    <= 1'b0;
            beat_q    <= '0;
            pkt_q     <= '0;
            err_q     <= '0;
        end else if (clear_in) begin
            stalled_q <= 1'b0;
            cnt_q     <= '0;
            full_q    <= 1'b0;
            beat_q    <= '0;
            pkt_q     <= '0;
            err_q     <= '0;
        end else begin
            stalled_q <= s_axis.tvalid & ~tready_q;
            snap_q    <= in_rec;
            if (hs) begin
                if (beat_q != '1) beat_q <= beat_q + CNT_W'(1);
                if (s_axis.tlast && pkt_q != '1) pkt_q <= pkt_q + CNT_W'(1);
                if (!full_q) begin
                    cnt_q  <= cnt_q + (AW + 1)'(1);
                    full_q <= (cnt_q == LAST_IDX);
                end
            end
            if (drop_set) err_q[ERR_VALID_DROP]     <= 1'b1;
            if (chg_set)  err_q[ERR_PAYLOAD_CHANGE] <= 1'b1;
        end
    end

    // Capture memory holds its contents across clear; only the pointer rewinds.
    always_ff @(posedge aclk) begin
        if (aresetn && !clear_in && hs && !full_q) mem[cnt_q[AW-1:0]] <= in_rec;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) rd_q <= '0;
        else          rd_q <= mem[rd_addr_in];
    end

`ifdef AXIS_SINK_DISPLAY_EN
    always_ff @(posedge aclk) begin
        if (aresetn && !clear_in) begin
            if (hs)
                $display("%0t axis_sink beat: tdata=%h tstrb=%h tkeep=%h tlast=%b tid=%h tdest=%h tuser=%h",
                         $time, s_axis.tdata, s_axis.tstrb, s_axis.tkeep, s_axis.tlast,
                         s_axis.tid, s_axis.tdest, s_axis.tuser);
            if (drop_set && !err_q[ERR_VALID_DROP])
                $display("%0t axis_sink error: VALID_DROP", $time);
            if (chg_set && !err_q[ERR_PAYLOAD_CHANGE])
                $display("%0t axis_sink error: PAYLOAD_CHANGE", $time);
        end
    end
`endif

    assign rd_data_out      = rd_q;
    assign capture_cnt_out  = cnt_q;
    assign capture_full_out = full_q;
    assign beat_cnt_out     = beat_q;
    assign pkt_cnt_out      = pkt_q;
    assign err_flags_out    = err_q;

endmodule

// File: tb/tb_axi_stream_monitor_sink.sv
// Directed bench for axi_stream_monitor_sink: six instances covering each ready mode and a shallow capture.
module tb_axi_stream_monitor_sink;

    logic        aclk = 1'b0;
    logic        aresetn, clear;
    logic [15:0] tdata;
    logic [1:0]  tstrb, tkeep;
    logic        tlast, tid, tdest, tuser;
    logic        tv [6];
    logic [5:0]  rd_addr;
    logic [1:0]  rd_addr4;

    // Index: 0 always-ready, 1 lfsr thresh 0, 2 lfsr thresh 256, 3 lfsr thresh 128, 4 periodic 1/4
    logic [23:0] rdd  [5];
    logic [6:0]  ccnt [5];
    logic        full [5];
    logic [31:0] beat [5];
    logic [31:0] pkt  [5];
    logic [1:0]  err  [5];
    logic [23:0] rdd4;
    logic [2:0]  ccnt4;
    logic        full4;
    logic [31:0] beat4, pkt4;
    logic [1:0]  err4;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 aclk = ~aclk;

    axi_stream_monitor_sink_if sif0 ();
    axi_stream_monitor_sink_if sif1 ();
    axi_stream_monitor_sink_if sif2 ();
    axi_stream_monitor_sink_if sif3 ();
    axi_stream_monitor_sink_if sif4 ();
    axi_stream_monitor_sink_if sif5 ();

`define TB_BIND(IFN, IDX) \
    assign IFN.tdata = tdata; assign IFN.tstrb = tstrb; assign IFN.tkeep = tkeep; \
    assign IFN.tlast = tlast; assign IFN.tid = tid; assign IFN.tdest = tdest; \
    assign IFN.tuser = tuser; assign IFN.tvalid = tv[IDX];
    `TB_BIND(sif0, 0)
    `TB_BIND(sif1, 1)
    `TB_BIND(sif2, 2)
    `TB_BIND(sif3, 3)
    `TB_BIND(sif4, 4)
    `TB_BIND(sif5, 5)
`undef TB_BIND

`define TB_PORTS(IFN, IDX) \
    .aclk(aclk), .aresetn(aresetn), .s_axis(IFN), .clear_in(clear), .rd_addr_in(rd_addr), \
    .rd_data_out(rdd[IDX]), .capture_cnt_out(ccnt[IDX]), .capture_full_out(full[IDX]), \
    .beat_cnt_out(beat[IDX]), .pkt_cnt_out(pkt[IDX]), .err_flags_out(err[IDX])
    axi_stream_monitor_sink #(.READY_MODE(0))                      u_m0   (`TB_PORTS(sif0, 0));
    axi_stream_monitor_sink #(.READY_MODE(1), .READY_THRESH(0))    u_l0   (`TB_PORTS(sif1, 1));
    axi_stream_monitor_sink #(.READY_MODE(1), .READY_THRESH(256))  u_l256 (`TB_PORTS(sif2, 2));
    axi_stream_monitor_sink #(.READY_MODE(1), .READY_THRESH(128))  u_l128 (`TB_PORTS(sif3, 3));
    axi_stream_monitor_sink #(.READY_MODE(2), .READY_PERIOD(4), .READY_DUTY(1)) u_p (`TB_PORTS(sif4, 4));
`undef TB_PORTS

    axi_stream_monitor_sink #(.READY_MODE(0), .CAPTURE_DEPTH(4)) u_d4 (
        .aclk(aclk), .aresetn(aresetn), .s_axis(sif5), .clear_in(clear), .rd_addr_in(rd_addr4),
        .rd_data_out(rdd4), .capture_cnt_out(ccnt4), .capture_full_out(full4),
        .beat_cnt_out(beat4), .pkt_cnt_out(pkt4), .err_flags_out(err4));

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // Record with the fixed sideband used throughout: tuser=1 tid=0 tdest=1 tkeep=11 tstrb=01
    function automatic logic [23:0] rec(input logic [15:0] d, input logic l);
        return {l, 1'b1, 1'b0, 1'b1, 2'b11, 2'b01, d};
    endfunction

    function automatic logic [15:0] step(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    // Must start on the cycle right after reset release.
    task automatic ready_pattern(input int ncyc, input string tag);
        logic [15:0] m = 16'hACE1;
        logic        exp_r;
        logic        hand [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        int          bad_z = 0, bad_f = 0, bad_r = 0, bad_p = 0;
        for (int k = 1; k <= ncyc; k++) begin
            exp_r = (m[7:0] < 8'd128);
            m     = step(m);
            tick();
            if (sif1.tready !== 1'b0) bad_z++;
            if (sif2.tready !== 1'b1) bad_f++;
            if (sif3.tready !== exp_r) bad_r++;
            if (sif4.tready !== ((k - 1) % 4 == 0)) bad_p++;
            if (k <= 4) check($sformatf("%s_lfsr_edge%0d", tag, k), 64'(sif3.tready), 64'(hand[k-1]));
        end
        check({tag, "_thresh0_bad_cycles"},   64'(bad_z), 64'(0));
        check({tag, "_thresh256_bad_cycles"}, 64'(bad_f), 64'(0));
        check({tag, "_thresh128_bad_cycles"}, 64'(bad_r), 64'(0));
        check({tag, "_periodic_bad_cycles"},  64'(bad_p), 64'(0));
        check({tag, "_mode0_ready"},          64'(sif0.tready), 64'(1));
    endtask

    typedef struct {
        logic        tv;
        logic [15:0] data;
        logic        last;
        logic        clr;
        logic [5:0]  ra;
        logic        chk_rd;
        logic [23:0] erd;
        logic [31:0] eb;
        logic [31:0] ep;
        logic [6:0]  ecc;
    } vec_t;

    initial begin
        vec_t tbl [15];
        int   ones;

        aresetn = 1'b0; clear = 1'b0; tdata = '0; tlast = 1'b0;
        tstrb = 2'b01; tkeep = 2'b11; tid = 1'b0; tdest = 1'b1; tuser = 1'b1;
        rd_addr = '0; rd_addr4 = '0;
        for (int i = 0; i < 6; i++) tv[i] = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_tready",   64'(sif0.tready), 64'(0));
        check("rst_beat",     64'(beat[0]), 64'(0));
        check("rst_pkt",      64'(pkt[0]),  64'(0));
        check("rst_err",      64'(err[0]),  64'(0));
        check("rst_ccnt",     64'(ccnt[0]), 64'(0));
        check("rst_rd_data",  64'(rdd[0]),  64'(0));
        check("rst_full_d4",  64'(full4),   64'(0));
        aresetn = 1'b1;

        // Ready patterns of every mode from reset release
        ready_pattern(40, "init");

        // Mode 0: ten beats, reads, then clear colliding with a handshake
        for (int i = 0; i < 10; i++)
            tbl[i] = '{1'b1, 16'(i), (i == 4 || i == 9), 1'b0, 6'd0, 1'b0, 24'd0,
                       32'(i + 1), (i >= 9) ? 32'd2 : (i >= 4) ? 32'd1 : 32'd0, 7'(i + 1)};
        tbl[10] = '{1'b0, 16'h0,  1'b0, 1'b0, 6'd3, 1'b1, rec(16'd3, 1'b0), 32'd10, 32'd2, 7'd10};
        tbl[11] = '{1'b0, 16'h0,  1'b0, 1'b0, 6'd9, 1'b1, rec(16'd9, 1'b1), 32'd10, 32'd2, 7'd10};
        tbl[12] = '{1'b1, 16'h55, 1'b1, 1'b1, 6'd0, 1'b0, 24'd0,            32'd0,  32'd0, 7'd0};
        tbl[13] = '{1'b1, 16'h66, 1'b0, 1'b0, 6'd0, 1'b1, rec(16'd0, 1'b0), 32'd1,  32'd0, 7'd1};
        tbl[14] = '{1'b0, 16'h0,  1'b0, 1'b0, 6'd0, 1'b1, rec(16'h66, 1'b0), 32'd1, 32'd0, 7'd1};
        for (int i = 0; i < 15; i++) begin
            tv[0] = tbl[i].tv; tdata = tbl[i].data; tlast = tbl[i].last;
            clear = tbl[i].clr; rd_addr = tbl[i].ra;
            tick();
            check($sformatf("row%0d_beat", i), 64'(beat[0]), 64'(tbl[i].eb));
            check($sformatf("row%0d_pkt", i),  64'(pkt[0]),  64'(tbl[i].ep));
            check($sformatf("row%0d_ccnt", i), 64'(ccnt[0]), 64'(tbl[i].ecc));
            check($sformatf("row%0d_err", i),  64'(err[0]),  64'(0));
            if (tbl[i].chk_rd) check($sformatf("row%0d_rd", i), 64'(rdd[0]), 64'(tbl[i].erd));
        end
        tv[0] = 1'b0; clear = 1'b0; tlast = 1'b0;

        // Periodic 1-in-4: 32 cycles of held tvalid accept 8 beats
        tdata = 16'h1234;
        tv[4] = 1'b1;
        ones  = 0;
        for (int k = 0; k < 32; k++) begin
            tick();
            if (sif4.tready === 1'b1) ones++;
        end
        tv[4] = 1'b0;
        check("per_ready_ones", 64'(ones),    64'(8));
        check("per_beats",      64'(beat[4]), 64'(8));
        check("per_ccnt",       64'(ccnt[4]), 64'(8));
        check("per_pkt",        64'(pkt[4]),  64'(0));
        check("per_err",        64'(err[4]),  64'(0));

        // Stability violations against the never-ready sink
        tdata = 16'hAAAA; tv[1] = 1'b1; tick();
        check("stall_first_err",  64'(err[1]), 64'(2'b00));
        tv[1] = 1'b0; tick();
        check("stall_drop_err",   64'(err[1]), 64'(2'b01));
        tdata = 16'hBBBB; tv[1] = 1'b1; tick();
        check("stall_again_err",  64'(err[1]), 64'(2'b01));
        tdata = 16'hBBBC; tick();
        check("stall_change_err", 64'(err[1]), 64'(2'b11));
        check("stall_no_beats",   64'(beat[1]), 64'(0));
        tv[1] = 1'b0; clear = 1'b1; tick();
        clear = 1'b0;
        check("stall_clear_err",  64'(err[1]), 64'(2'b00));
        tick();
        check("stall_after_clear", 64'(err[1]), 64'(2'b00));

        // Depth-4 capture overflows after four beats
        tv[5] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tdata = 16'h0010 + 16'(i);
            tick();
            if (i == 2) begin
                check("d4_full_at3", 64'(full4), 64'(0));
                check("d4_ccnt_at3", 64'(ccnt4), 64'(3));
            end
        end
        tv[5] = 1'b0;
        check("d4_full",  64'(full4), 64'(1));
        check("d4_ccnt",  64'(ccnt4), 64'(4));
        check("d4_beats", 64'(beat4), 64'(6));
        rd_addr4 = 2'd3; tick();
        check("d4_mem3", 64'(rdd4), 64'(rec(16'h0013, 1'b0)));
        rd_addr4 = 2'd0; tick();
        check("d4_mem0", 64'(rdd4), 64'(rec(16'h0010, 1'b0)));
        check("d4_full_hold", 64'(full4), 64'(1));

        // Asynchronous reset in the middle of a packet
        tv[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tdata = 16'h0200 + 16'(i);
            tick();
        end
        check("mid_beats", 64'(beat[0]), 64'(3));
        #2 aresetn = 1'b0;
        #1;
        check("async_tready", 64'(sif0.tready), 64'(0));
        check("async_beat",   64'(beat[0]),     64'(0));
        check("async_ccnt",   64'(ccnt[0]),     64'(0));
        tv[0] = 1'b0;
        tick();
        check("held_tready",  64'(sif0.tready), 64'(0));
        aresetn = 1'b1;

        // Same seed reproduces the same backpressure after reset
        ready_pattern(8, "rerun");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
